// File: rtl/conv_pkg.sv
// ============================================================
// conv_pkg : shared types and arithmetic helpers for conv2d_stream
// Revision 1.0
// ============================================================
`default_nettype none

package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    function automatic int acc_width(input int w, input int k);
        return 2 * w + $clog2(k * k);
    endfunction

    // Floor shift, optional ReLU, then clamp to a signed w-bit range.
    function automatic logic signed [63:0] shift_relu_sat(
        input logic signed [63:0] acc,
        input int unsigned        sh,
        input logic               relu,
        input int unsigned        w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = acc >>> sh;
        if (relu && (s < 64'sd0)) s = 64'sd0;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv2d_stream_if.sv
// ============================================================
// conv2d_stream_if : pixel-in / result-out valid-ready stream pair
// Revision 1.0
// ============================================================
`default_nettype none

interface conv2d_stream_if #(
    parameter int WIDTH_BIT = 16
) ();
    import conv_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH_BIT-1:0] in_pixel;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [WIDTH_BIT-1:0] out_pixel;
    logic                        out_last;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_last
    );
endinterface

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// ============================================================
// conv_line_buffer : K-1 row history, column addressed, read-before-write
// Revision 1.0
// ============================================================
`default_nettype none

module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W     = 256,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16
) (
    input  wire logic                         clock,
    input  wire logic                         en,
    input  wire logic [$clog2(IMG_W)-1:0]     col,
    input  wire logic signed [WIDTH_BIT-1:0]  pixel,
    output logic signed [WIDTH_BIT-1:0]       taps [SIZEKer-1]
);

    // Row 0 is the oldest line; row SIZEKer-2 is the line just above.
    logic signed [WIDTH_BIT-1:0] mem [SIZEKer-1][IMG_W];

    always_comb begin
        for (int r = 0; r < SIZEKer - 1; r++) begin
            taps[r] = mem[r][col];
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            for (int r = 0; r < SIZEKer - 2; r++) begin
                mem[r][col] <= mem[r+1][col];
            end
            mem[SIZEKer-2][col] <= pixel;
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv2d_stream.sv
// ============================================================
// conv2d_stream : streaming KxK convolution with shift, ReLU, saturation
// Revision 1.0
// ============================================================
`default_nettype none

module conv2d_stream
    import conv_pkg::*;
#(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16,
    parameter int ACC_W     = acc_width(WIDTH_BIT, SIZEKer)
) (
    input  wire logic                                      clock,
    input  wire logic                                      nreset,
    input  wire logic                                      start,
    output logic                                           busy,
    output logic                                           done,
    input  wire logic                                      ker_we,
    input  wire logic [$clog2(SIZEKer*SIZEKer)-1:0]        ker_addr,
    input  wire logic signed [WIDTH_BIT-1:0]               ker_data,
    input  wire logic [$clog2(2*WIDTH_BIT)-1:0]            shift,
    input  wire logic                                      relu_en,
    conv2d_stream_if.slave                                 strm
);

    localparam int KK      = SIZEKer * SIZEKer;
    localparam int COL_W   = $clog2(IMG_W);
    localparam int ROW_W   = $clog2(IMG_H);
    localparam int SHIFT_W = $clog2(2 * WIDTH_BIT);
    localparam int PROD_W  = 2 * WIDTH_BIT;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    conv_state_t                 state;
    logic signed [WIDTH_BIT-1:0] ker  [KK];
    logic signed [WIDTH_BIT-1:0] win  [SIZEKer][SIZEKer];
    logic signed [WIDTH_BIT-1:0] nxt  [SIZEKer][SIZEKer];
    logic signed [WIDTH_BIT-1:0] taps [SIZEKer-1];
    logic [COL_W-1:0]            col;
    logic [ROW_W-1:0]            row;
    logic [SHIFT_W-1:0]          shift_q;
    logic                        relu_q;
    logic                        advance;
    logic                        accept;
    logic                        win_valid;
    logic                        last_pix;
    logic signed [ACC_W-1:0]     acc;
    logic signed [WIDTH_BIT-1:0] result;

    assign advance       = !strm.out_valid || strm.out_ready;
    assign strm.in_ready = (state == RUN) && advance;
    assign accept        = strm.in_ready && strm.in_valid;
    assign win_valid     = (row >= ROW_W'(SIZEKer - 1)) && (col >= COL_W'(SIZEKer - 1));
    assign last_pix      = (row == ROW_MAX) && (col == COL_MAX);

    conv_line_buffer #(
        .IMG_W     (IMG_W),
        .SIZEKer   (SIZEKer),
        .WIDTH_BIT (WIDTH_BIT)
    ) u_line_buffer (
        .clock (clock),
        .en    (accept),
        .col   (col),
        .pixel (strm.in_pixel),
        .taps  (taps)
    );

    // Window as it will look after this accept; the MAC works on it so the
    // result can be registered on the same edge that takes the pixel.
    always_comb begin
        for (int r = 0; r < SIZEKer; r++) begin
            for (int c = 0; c < SIZEKer - 1; c++) begin
                nxt[r][c] = win[r][c+1];
            end
        end
        for (int r = 0; r < SIZEKer - 1; r++) begin
            nxt[r][SIZEKer-1] = taps[r];
        end
        nxt[SIZEKer-1][SIZEKer-1] = strm.in_pixel;
    end

    always_comb begin : mac
        logic signed [PROD_W-1:0] p;
        acc = '0;
        p   = '0;
        for (int r = 0; r < SIZEKer; r++) begin
            for (int c = 0; c < SIZEKer; c++) begin
                p   = PROD_W'(nxt[r][c]) * PROD_W'(ker[r*SIZEKer+c]);
                acc = acc + ACC_W'(p);
            end
        end
    end

    assign result = WIDTH_BIT'(shift_relu_sat(64'(acc), 32'(shift_q), relu_q, WIDTH_BIT));

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    shift_q <= shift;
                    relu_q  <= relu_en;
                end
                RUN: if (accept && last_pix) state <= DRAIN;
                DRAIN: if (strm.out_valid && strm.out_ready) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < KK; i++) ker[i] <= '0;
        end else if ((state == IDLE) && ker_we && (32'(ker_addr) < KK)) begin
            ker[ker_addr] <= ker_data;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            col            <= '0;
            row            <= '0;
            strm.out_valid <= 1'b0;
            strm.out_pixel <= '0;
            strm.out_last  <= 1'b0;
            for (int r = 0; r < SIZEKer; r++)
                for (int c = 0; c < SIZEKer; c++)
                    win[r][c] <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                col <= '0;
                row <= '0;
            end
            if (accept) begin
                win <= nxt;
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (accept && win_valid) begin
                strm.out_valid <= 1'b1;
                strm.out_pixel <= result;
                strm.out_last  <= last_pix;
            end else if (strm.out_ready) begin
                strm.out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv2d_stream.sv
// ============================================================
// tb_conv2d_stream : randomized scoreboard bench for conv2d_stream (8x8, K=3)
// Revision 1.0
// ============================================================
`default_nettype none

module tb_conv2d_stream;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int K    = 3;
    localparam int NPIX = W * H;
    localparam int NRES = (W - K + 1) * (H - K + 1);

    typedef struct {
        logic signed [15:0] pix;
        logic               last;
    } exp_t;

    logic               clock = 1'b0;
    logic               nreset = 1'b0;
    logic               start = 1'b0;
    logic               busy;
    logic               done;
    logic               ker_we = 1'b0;
    logic [3:0]         ker_addr = '0;
    logic signed [15:0] ker_data = '0;
    logic [4:0]         shift = '0;
    logic               relu_en = 1'b0;

    conv2d_stream_if #(.WIDTH_BIT(16)) sif ();

    conv2d_stream #(
        .IMG_W     (W),
        .IMG_H     (H),
        .SIZEKer   (K),
        .WIDTH_BIT (16)
    ) dut (
        .clock    (clock),
        .nreset   (nreset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ker_we   (ker_we),
        .ker_addr (ker_addr),
        .ker_data (ker_data),
        .shift    (shift),
        .relu_en  (relu_en),
        .strm     (sif)
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    int   res_cnt     = 0;
    int   stalls      = 0;
    bit   stress_ready = 1'b0;
    int   img  [NPIX];
    int   kern [K*K];

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Direct convolution over the frame array, in output raster order.
    function automatic void push_expected(input int sh, input bit relu);
        longint s;
        exp_t   e;
        for (int i = 0; i <= H - K; i++) begin
            for (int j = 0; j <= W - K; j++) begin
                s = 0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        s += longint'(img[(i+r)*W + j + c]) * longint'(kern[r*K + c]);
                s = s >>> sh;
                if (relu && s < 0) s = 0;
                if (s > 32767)  s = 32767;
                if (s < -32768) s = -32768;
                e.pix  = 16'(s);
                e.last = (i == H - K) && (j == W - K);
                exp_q.push_back(e);
            end
        end
    endfunction

    initial begin : ready_driver
        forever begin
            @(posedge clock);
            #1;
            sif.out_ready = stress_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        bit                 prev_stall = 1'b0;
        logic signed [15:0] prev_pix = '0;
        logic               prev_last = 1'b0;
        exp_t               e;
        forever begin
            @(negedge clock);
            if (!nreset) begin
                prev_stall = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("stall_out_valid", sif.out_valid, 1);
                chk("stall_out_pixel", sif.out_pixel, prev_pix);
                chk("stall_out_last",  sif.out_last,  prev_last);
            end
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_output: actual pixel %0d required no output", sif.out_pixel);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pixel", sif.out_pixel, e.pix);
                    chk("out_last",  sif.out_last,  e.last);
                    res_cnt++;
                end
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_pix   = sif.out_pixel;
            prev_last  = sif.out_last;
        end
    end

    task automatic load_kernel();
        for (int i = 0; i < K*K; i++) begin
            @(posedge clock); #1;
            ker_we   = 1'b1;
            ker_addr = 4'(i);
            ker_data = 16'(kern[i]);
        end
        @(posedge clock); #1;
        ker_we = 1'b0;
    endtask

    task automatic start_frame(input int sh, input bit relu);
        @(posedge clock); #1;
        shift   = 5'(sh);
        relu_en = relu;
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int first, input int n, input bit stress, input bit gate);
        int waited;
        for (int idx = first; idx < first + n; idx++) begin
            if (stress && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
            sif.in_valid = 1'b1;
            sif.in_pixel = 16'(img[idx]);
            if (gate && idx == 10) begin
                ker_we   = 1'b1;
                ker_addr = 4'd4;
                ker_data = -16'sd77;
                start    = 1'b1;
            end
            waited = 0;
            @(negedge clock);
            while (!sif.in_ready && waited < 200) begin
                waited++;
                @(negedge clock);
            end
            stalls += waited;
            if (waited >= 200) chk("in_ready_timeout", waited, 0);
            @(posedge clock); #1;
            sif.in_valid = 1'b0;
            ker_we       = 1'b0;
            start        = 1'b0;
        end
    endtask

    task automatic finish_frame(input bit stress);
        int waited = 0;
        while (done_cnt == 0 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        chk("done_seen", done_cnt > 0, 1);
        stress_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("done_pulses",   done_cnt, 1);
        chk("results_count", res_cnt, NRES);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_idle",     busy, 0);
        if (!stress) chk("throughput_stalls", stalls, 0);
    endtask

    task automatic run_frame(input int sh, input bit relu, input bit stress, input bit gate);
        push_expected(sh, relu);
        res_cnt      = 0;
        done_cnt     = 0;
        stalls       = 0;
        stress_ready = stress;
        start_frame(sh, relu);
        feed(0, NPIX, stress, gate);
        finish_frame(stress);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_done"},      done, 0);
        chk({tag, "_in_ready"},  sif.in_ready, 0);
        chk({tag, "_out_valid"}, sif.out_valid, 0);
        chk({tag, "_out_pixel"}, sif.out_pixel, 0);
        chk({tag, "_out_last"},  sif.out_last, 0);
    endtask

    task automatic fill_img_const(input int v);
        for (int i = 0; i < NPIX; i++) img[i] = v;
    endtask

    task automatic fill_img_random(input int lo, input int hi);
        for (int i = 0; i < NPIX; i++) img[i] = lo + int'($urandom_range(0, hi - lo));
    endtask

    task automatic set_kernel_random();
        for (int i = 0; i < K*K; i++) kern[i] = int'($urandom_range(0, 100)) - 50;
    endtask

    initial begin : main
        int sh;
        sif.in_valid  = 1'b0;
        sif.in_pixel  = '0;
        sif.out_ready = 1'b1;
        nreset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        nreset = 1'b1;

        // Identity kernel over a ramp: result(i,j) = (i+1)*8 + (j+1).
        for (int i = 0; i < K*K; i++) kern[i] = 0;
        kern[4] = 1;
        load_kernel();
        for (int i = 0; i < NPIX; i++) img[i] = i;
        run_frame(0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < K*K; i++) kern[i] = 1;
        load_kernel();
        fill_img_const(100);    run_frame(0, 1'b0, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b0, 1'b0);
        fill_img_const(-100);   run_frame(2, 1'b0, 1'b0, 1'b0);
        fill_img_const(32767);  run_frame(0, 1'b0, 1'b0, 1'b0);
        fill_img_const(-32768); run_frame(0, 1'b0, 1'b0, 1'b0);
        run_frame(0, 1'b1, 1'b0, 1'b0);

        // Same random frame unstalled, then under backpressure and input gaps.
        set_kernel_random();
        load_kernel();
        fill_img_random(-1000, 1000);
        sh = int'($urandom_range(0, 7));
        run_frame(sh, 1'b0, 1'b0, 1'b0);
        run_frame(sh, 1'b0, 1'b1, 1'b0);
        fill_img_random(-3000, 3000);
        run_frame(int'($urandom_range(0, 4)), 1'b1, 1'b1, 1'b0);

        // ker_we and a second start during RUN must not disturb the frame.
        fill_img_random(-500, 500);
        run_frame(1, 1'b0, 1'b0, 1'b1);
        run_frame(0, 1'b0, 1'b0, 1'b0);

        // Reset partway through a frame.
        for (int i = 0; i < NPIX; i++) img[i] = i;
        push_expected(0, 1'b0);
        stress_ready = 1'b0;
        start_frame(0, 1'b0);
        feed(0, 20, 1'b0, 1'b0);
        #1;
        nreset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clock); #1;
        nreset = 1'b1;

        // Kernel was cleared by reset: an unloaded frame convolves to zero.
        for (int i = 0; i < K*K; i++) kern[i] = 0;
        run_frame(0, 1'b0, 1'b0, 1'b0);
        set_kernel_random();
        load_kernel();
        run_frame(0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
